// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the pattern sequencer: FSM state encodings, RGB
// channel layout, the default dwell table and the per-channel dimming helper.
package pattern_sequencer_pkg;

  // Width of the fade level; FADE_STEPS is limited to 1..3.
  localparam int LVL_W = 2;

  // Each colour channel is 2 bits wide: {R1R0,G1G0,B1B0}.
  localparam int CH_W      = 2;
  localparam int RGB_R_OFS = 4;
  localparam int RGB_G_OFS = 2;
  localparam int RGB_B_OFS = 0;

  // FSM state encodings, kept as plain constants for legacy compatibility.
  typedef logic [1:0] fsm_state_t;
  localparam logic [1:0] ST_SHOW     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_FADE_IN  = 2'd2;

  // Default dwell table in frames. Index 0 is the rightmost entry.
  localparam logic [3:0][9:0] DEFAULT_DWELL = {10'd240, 10'd360, 10'd480, 10'd240};

  // Saturating subtract of the fade level from one 2-bit colour channel.
  function automatic logic [CH_W-1:0] dim_channel(input logic [CH_W-1:0] c,
                                                  input logic [LVL_W-1:0] lvl);
    logic [CH_W-1:0] res;
    if (c > lvl) begin
      res = c - lvl;
    end else begin
      res = {CH_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/pattern_sequencer_rgb_dimmer.sv
// rgb_dimmer: purely combinational dimmer. Every 2-bit channel of the input
// pixel is reduced by the fade level, saturating at zero. Shared with the
// video output stage, so it carries no state and no clock.
module rgb_dimmer
  import pattern_sequencer_pkg::*;
#(
  parameter int RGB_W = 6
) (
  input  logic [RGB_W-1:0] i_rgb,
  input  logic [LVL_W-1:0] i_level,
  output logic [RGB_W-1:0] o_rgb
);

  localparam int NUM_CH = RGB_W / CH_W;

  // Apply the saturating dim to each channel independently.
  always_comb begin
    o_rgb = {RGB_W{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      o_rgb[ch*CH_W +: CH_W] = dim_channel(i_rgb[ch*CH_W +: CH_W], i_level);
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: cycles through NUM_PATTERNS generators. Each pattern is
// shown for its own dwell time (in frames); a skip request cuts the dwell
// short. Every switch fades the current pattern out over FADE_STEPS frames,
// changes the selection at a frame origin, then fades the new one back in.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int CNT_W        = 10,
  parameter int RGB_W        = 6,
  parameter int FADE_STEPS   = 3,
  parameter int PAUSE_HOLDS  = 1
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    vsync,
  input  logic                                                    paused,
  input  logic                                                    next_req,
  input  logic [NUM_PATTERNS*CNT_W-1:0]                           dwell_flat,
  input  logic [NUM_PATTERNS*RGB_W-1:0]                           pat_rgb_flat,
  output logic [((NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1)-1:0] pattern_sel,
  output logic [NUM_PATTERNS-1:0]                                 pattern_en,
  output logic [NUM_PATTERNS-1:0]                                 next_frame,
  output logic                                                    switching,
  output logic [RGB_W-1:0]                                        rgb
);

  localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FADE_STEPS);
  localparam logic             HOLD_EN   = (PAUSE_HOLDS != 0);

  // State registers
  logic             r_vsync_q;
  fsm_state_t       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_dwell_cnt;
  logic [LVL_W-1:0] r_fade_lvl;
  logic             r_skip_pend;

  // Combinational signals
  logic             w_fe;
  logic             w_anim;
  logic             w_hold;
  logic             w_expire;
  logic [CNT_W-1:0] w_dwell;
  logic [CNT_W-1:0] w_dwell_m1;
  logic [RGB_W-1:0] w_pat;
  logic [RGB_W-1:0] w_rgb_dim;
  fsm_state_t       w_state_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LVL_W-1:0] w_lvl_nxt;
  logic             w_skip_nxt;

  // vsync is active low, so the frame origin is its rising edge. The delayed
  // copy resets high so that a vsync held high after reset gives no edge.
  assign w_fe   = vsync & ~r_vsync_q;
  assign w_anim = w_fe & ~paused & (r_state == ST_SHOW);
  assign w_hold = paused & HOLD_EN;

  // Pick the dwell entry and generator pixel belonging to the active pattern.
  always_comb begin
    w_dwell = {CNT_W{1'b0}};
    w_pat   = {RGB_W{1'b0}};
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_dwell = dwell_flat[i*CNT_W +: CNT_W];
        w_pat   = pat_rgb_flat[i*RGB_W +: RGB_W];
      end else begin
        w_dwell = w_dwell;
        w_pat   = w_pat;
      end
    end
  end

  // A dwell of 0 behaves like 1. Using >= lets a dwell lowered below the
  // running count expire on the very next frame edge.
  always_comb begin
    if (w_dwell == {CNT_W{1'b0}}) begin
      w_dwell_m1 = {CNT_W{1'b0}};
    end else begin
      w_dwell_m1 = w_dwell - CNT_W'(1);
    end
    w_expire = (r_dwell_cnt >= w_dwell_m1);
  end

  // Next-state logic. A skip request arriving in SHOW is folded in straight
  // away, so a request coinciding with the edge is honoured on that edge.
  // Expiry and skip together still produce a single advance because both
  // just trigger the same SHOW -> FADE_OUT transition.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_dwell_cnt;
    w_lvl_nxt   = r_fade_lvl;
    if ((r_state == ST_SHOW) && next_req) begin
      w_skip_nxt = 1'b1;
    end else begin
      w_skip_nxt = r_skip_pend;
    end
    if (w_fe) begin
      case (r_state)
        ST_SHOW: begin
          if (w_expire || w_skip_nxt) begin
            w_state_nxt = ST_FADE_OUT;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_lvl_nxt   = LVL_W'(1);
            w_skip_nxt  = 1'b0;
          end else if (!w_hold) begin
            w_cnt_nxt = r_dwell_cnt + CNT_W'(1);
          end else begin
            w_cnt_nxt = r_dwell_cnt;
          end
        end
        ST_FADE_OUT: begin
          // At full dim the selection moves on; the level stays at its
          // maximum for one more frame while the new pattern is hidden.
          if (r_fade_lvl == LVL_FULL) begin
            w_state_nxt = ST_FADE_IN;
            if (r_sel == SEL_LAST) begin
              w_sel_nxt = {SEL_W{1'b0}};
            end else begin
              w_sel_nxt = r_sel + SEL_W'(1);
            end
          end else begin
            w_lvl_nxt = r_fade_lvl + LVL_W'(1);
          end
        end
        ST_FADE_IN: begin
          if (r_fade_lvl <= LVL_W'(1)) begin
            w_state_nxt = ST_SHOW;
            w_lvl_nxt   = {LVL_W{1'b0}};
          end else begin
            w_lvl_nxt = r_fade_lvl - LVL_W'(1);
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean, undimmed SHOW.
          w_state_nxt = ST_SHOW;
          w_sel_nxt   = {SEL_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_lvl_nxt   = {LVL_W{1'b0}};
          w_skip_nxt  = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Register all sequencing state; reset abandons any fade in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_q   <= 1'b1;
      r_state     <= ST_SHOW;
      r_sel       <= {SEL_W{1'b0}};
      r_dwell_cnt <= {CNT_W{1'b0}};
      r_fade_lvl  <= {LVL_W{1'b0}};
      r_skip_pend <= 1'b0;
    end else begin
      r_vsync_q   <= vsync;
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_dwell_cnt <= w_cnt_nxt;
      r_fade_lvl  <= w_lvl_nxt;
      r_skip_pend <= w_skip_nxt;
    end
  end

  // Decode the enable one-hot and the animation pulse for the active pattern.
  always_comb begin
    pattern_en = {NUM_PATTERNS{1'b0}};
    next_frame = {NUM_PATTERNS{1'b0}};
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        pattern_en[i] = 1'b1;
        next_frame[i] = w_anim;
      end else begin
        pattern_en[i] = 1'b0;
        next_frame[i] = 1'b0;
      end
    end
  end

  assign pattern_sel = r_sel;
  assign switching   = (r_state == ST_FADE_OUT) || (r_state == ST_FADE_IN);

  rgb_dimmer #(
    .RGB_W (RGB_W)
  ) u_dimmer (
    .i_rgb   (w_pat),
    .i_level (r_fade_lvl),
    .o_rgb   (w_rgb_dim)
  );

  assign rgb = w_rgb_dim;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: two instances (dwell held / not held while
// paused) share all inputs. A frame-position reference model checks every
// cycle; a vector table and hand-written sequences cover the corner cases.
module tb_pattern_sequencer;

  localparam int NP = 3;
  localparam int CW = 10;
  localparam int RW = 6;
  localparam int FS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             vsync;
  logic             paused;
  logic             next_req;
  logic [NP*CW-1:0] dwell_flat;
  logic [NP*RW-1:0] pat_rgb_flat;

  logic [1:0]    d_sel [2];
  logic [NP-1:0] d_en  [2];
  logic [NP-1:0] d_nf  [2];
  logic          d_sw  [2];
  logic [RW-1:0] d_rgb [2];

  int total = 0;
  int bad   = 0;
  bit checking  = 1'b0;
  bit fixed_pat = 1'b1;

  // Reference model: position within a switch (0 = showing, 1..2*FS = fading)
  int m_sel   [2];
  int m_shown [2];
  int m_pos   [2];
  bit m_skip  [2];
  bit m_vq;
  int ph [2] = '{1, 0};

  always #5 clk = ~clk;

  pattern_sequencer #(.NUM_PATTERNS(NP), .CNT_W(CW), .RGB_W(RW), .FADE_STEPS(FS), .PAUSE_HOLDS(1)) dut_ph1 (
    .clk(clk), .rst(rst), .vsync(vsync), .paused(paused), .next_req(next_req),
    .dwell_flat(dwell_flat), .pat_rgb_flat(pat_rgb_flat),
    .pattern_sel(d_sel[0]), .pattern_en(d_en[0]), .next_frame(d_nf[0]),
    .switching(d_sw[0]), .rgb(d_rgb[0]));

  pattern_sequencer #(.NUM_PATTERNS(NP), .CNT_W(CW), .RGB_W(RW), .FADE_STEPS(FS), .PAUSE_HOLDS(0)) dut_ph0 (
    .clk(clk), .rst(rst), .vsync(vsync), .paused(paused), .next_req(next_req),
    .dwell_flat(dwell_flat), .pat_rgb_flat(pat_rgb_flat),
    .pattern_sel(d_sel[1]), .pattern_en(d_en[1]), .next_frame(d_nf[1]),
    .switching(d_sw[1]), .rgb(d_rgb[1]));

  typedef struct {
    bit       pz;
    bit       req;
    int       e_sel;
    int       e_rgb;
    int       e_sw;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dwell_of(input int p);
    return int'(dwell_flat[p*CW +: CW]);
  endfunction

  function automatic int level_of(input int pos);
    if (pos == 0) return 0;
    if (pos <= FS) return pos;
    return 2*FS + 1 - pos;
  endfunction

  function automatic int exp_rgb(input int p, input int lvl);
    int px = int'(pat_rgb_flat[p*RW +: RW]);
    int r = 0;
    for (int ch = 0; ch < 3; ch++) begin
      int c = (px >> (2*ch)) & 3;
      int d = (c > lvl) ? c - lvl : 0;
      r = r | (d << (2*ch));
    end
    return r;
  endfunction

  task automatic check_outputs();
    bit fe = vsync && !m_vq;
    for (int v = 0; v < 2; v++) begin
      int nf = (fe && !paused && m_pos[v] == 0) ? (1 << m_sel[v]) : 0;
      chk($sformatf("sel[%0d]", v), int'(d_sel[v]), m_sel[v]);
      chk($sformatf("en[%0d]", v), int'(d_en[v]), 1 << m_sel[v]);
      chk($sformatf("next_frame[%0d]", v), int'(d_nf[v]), nf);
      chk($sformatf("switching[%0d]", v), int'(d_sw[v]), (m_pos[v] != 0) ? 1 : 0);
      chk($sformatf("rgb[%0d]", v), int'(d_rgb[v]), exp_rgb(m_sel[v], level_of(m_pos[v])));
    end
  endtask

  task automatic model_update(input bit vs, input bit pz, input bit nr, input bit rs);
    bit fe = vs && !m_vq;
    for (int v = 0; v < 2; v++) begin
      if (rs) begin
        m_sel[v] = 0; m_shown[v] = 0; m_pos[v] = 0; m_skip[v] = 1'b0;
      end else begin
        if (m_pos[v] == 0 && nr) m_skip[v] = 1'b1;
        if (fe) begin
          if (m_pos[v] == 0) begin
            int dw = dwell_of(m_sel[v]);
            if (dw == 0) dw = 1;
            if (m_shown[v] + 1 >= dw || m_skip[v]) begin
              m_pos[v] = 1; m_shown[v] = 0; m_skip[v] = 1'b0;
            end else if (!(pz && ph[v] != 0)) begin
              m_shown[v]++;
            end
          end else begin
            m_pos[v]++;
            if (m_pos[v] == FS + 1) m_sel[v] = (m_sel[v] + 1) % NP;
            if (m_pos[v] == 2*FS + 1) m_pos[v] = 0;
          end
        end
      end
    end
    m_vq = rs ? 1'b1 : vs;
  endtask

  task automatic step(input bit vs, input bit pz, input bit nr, input bit rs);
    @(negedge clk);
    vsync = vs; paused = pz; next_req = nr; rst = rs;
    if (fixed_pat) pat_rgb_flat = {NP{6'h3F}};
    else pat_rgb_flat = (NP*RW)'($urandom);
    #1;
    if (checking) check_outputs();
    @(posedge clk);
    model_update(vs, pz, nr, rs);
  endtask

  // One frame: low phase (optional skip pulse on its first cycle), then the
  // rising edge on the first high cycle.
  task automatic frame(input bit pz, input bit req, input int nlow, input int nhigh);
    for (int i = 0; i < nlow; i++) step(1'b0, pz, req && (i == 0), 1'b0);
    for (int i = 0; i < nhigh; i++) step(1'b1, pz, 1'b0, 1'b0);
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 0, 6'h3F, 0};
    tbl[1] = '{1'b0, 1'b0, 0, 6'h3F, 0};
    tbl[2] = '{1'b0, 1'b0, 0, 6'h3F, 0};
    tbl[3] = '{1'b0, 1'b0, 0, 6'h2A, 1};
    tbl[4] = '{1'b0, 1'b0, 0, 6'h15, 1};
    tbl[5] = '{1'b0, 1'b0, 1, 6'h15, 1};
    tbl[6] = '{1'b0, 1'b0, 1, 6'h2A, 1};
    tbl[7] = '{1'b0, 1'b0, 1, 6'h3F, 0};

    rst = 1'b1; vsync = 1'b1; paused = 1'b0; next_req = 1'b0;
    dwell_flat = {10'd3, 10'd2, 10'd4};
    pat_rgb_flat = {NP{6'h3F}};
    m_vq = 1'b1;
    for (int v = 0; v < 2; v++) begin
      m_sel[v] = 0; m_shown[v] = 0; m_pos[v] = 0; m_skip[v] = 1'b0;
    end

    // Test 1: reset state, then expiry fade 0 -> 1
    do_reset();
    peek();
    for (int v = 0; v < 2; v++) begin
      chk("reset sel", int'(d_sel[v]), 0);
      chk("reset en", int'(d_en[v]), 1);
      chk("reset switching", int'(d_sw[v]), 0);
      chk("reset next_frame", int'(d_nf[v]), 0);
      chk("reset rgb", int'(d_rgb[v]), 6'h3F);
    end
    for (int r = 0; r < 8; r++) begin
      frame(tbl[r].pz, tbl[r].req, 2, 2);
      peek();
      for (int v = 0; v < 2; v++) begin
        chk($sformatf("tbl%0d sel", r), int'(d_sel[v]), tbl[r].e_sel);
        chk($sformatf("tbl%0d rgb", r), int'(d_rgb[v]), tbl[r].e_rgb);
        chk($sformatf("tbl%0d switching", r), int'(d_sw[v]), tbl[r].e_sw);
      end
    end

    // Test 2: skip on pattern 1, further requests during the fade dropped
    frame(1'b0, 1'b1, 2, 2);
    peek();
    chk("skip starts fade", int'(d_sw[0]), 1);
    frame(1'b0, 1'b1, 2, 2);
    frame(1'b0, 1'b1, 2, 2);
    frame(1'b0, 1'b0, 2, 2);
    frame(1'b0, 1'b0, 2, 2);
    peek();
    chk("single advance sel", int'(d_sel[0]), 2);
    chk("single advance switching", int'(d_sw[0]), 0);

    // Test 3: pattern 2 expires, selection wraps to 0
    for (int i = 0; i < 4; i++) frame(1'b0, 1'b0, 2, 2);
    peek();
    chk("before wrap en", int'(d_en[0]), 3'b100);
    frame(1'b0, 1'b0, 2, 2);
    peek();
    chk("after wrap en", int'(d_en[0]), 3'b001);
    frame(1'b0, 1'b0, 2, 2);
    frame(1'b0, 1'b0, 2, 2);

    // Test 4: ten paused frames; held variant frozen, free variant advances
    for (int i = 0; i < 10; i++) frame(1'b1, 1'b0, 2, 2);
    peek();
    chk("paused hold sel", int'(d_sel[0]), 0);
    chk("paused hold switching", int'(d_sw[0]), 0);
    chk("paused free sel", int'(d_sel[1]), 1);
    chk("paused free switching", int'(d_sw[1]), 1);

    // Test 5: zero dwell shows one frame; dwell lowered under the count
    dwell_flat = {10'd3, 10'd10, 10'd0};
    do_reset();
    frame(1'b0, 1'b0, 2, 2);
    peek();
    chk("dwell0 fade", int'(d_sw[0]), 1);
    for (int i = 0; i < 4; i++) frame(1'b0, 1'b0, 2, 2);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, 2, 2);
    peek();
    chk("count 3 still showing", int'(d_sw[0]), 0);
    chk("count 3 sel", int'(d_sel[0]), 1);
    dwell_flat = {10'd3, 10'd1, 10'd0};
    frame(1'b0, 1'b0, 2, 2);
    peek();
    chk("lowered dwell fade", int'(d_sw[0]), 1);

    // Test 6: reset during FADE_IN, vsync held high afterwards
    frame(1'b0, 1'b0, 2, 2);
    frame(1'b0, 1'b0, 2, 2);
    peek();
    chk("in fade-in sel", int'(d_sel[0]), 2);
    chk("in fade-in switching", int'(d_sw[0]), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    peek();
    for (int v = 0; v < 2; v++) begin
      chk("post-rst sel", int'(d_sel[v]), 0);
      chk("post-rst switching", int'(d_sw[v]), 0);
      chk("post-rst rgb", int'(d_rgb[v]), 6'h3F);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised run against the model
    fixed_pat = 1'b0;
    do_reset();
    for (int f = 0; f < 150; f++) begin
      if (f % 25 == 0) begin
        for (int p = 0; p < NP; p++) dwell_flat[p*CW +: CW] = CW'($urandom_range(0, 5));
      end
      frame($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(1, 3), $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
